// File: rtl/rival_spawn_ctrl_if.sv
// Rival controller bus: frame pacing and freeze in, rival position and score out.
// The controller uses the master modport; the consumer side uses slave.
interface rival_spawn_ctrl_if;
   logic       frame_tick;
   logic       stop;
   logic [9:0] rival_x;
   logic [9:0] rival_y;
   logic       rival_valid;
   logic [6:0] rival_random;
   logic       respawn;
   logic [7:0] score;

   modport master (
      input  frame_tick,
      input  stop,
      output rival_x,
      output rival_y,
      output rival_valid,
      output rival_random,
      output respawn,
      output score
   );

   modport slave (
      output frame_tick,
      output stop,
      input  rival_x,
      input  rival_y,
      input  rival_valid,
      input  rival_random,
      input  respawn,
      input  score
   );
endinterface

// File: rtl/rival_spawn_ctrl.sv
// Rival-car spawn/motion controller with a free-running 8-bit LFSR.
// Optional macro RIVAL_SPEEDUP_EN: speed steps up every 8 rivals cleared, capped at MAX_SPEED.
//
//   state    | meaning
//   ST_SPAWN | sample LFSR, place rival at the top of the road (single cycle unless stop)
//   ST_MOVE  | advance rival_y by speed on each frame_tick until it leaves the background
//   ST_GAP   | no rival on screen; count GAP_FRAMES ticks down, then respawn
module rival_spawn_ctrl #(
   parameter int         OFFSET_BG_X = 200,
   parameter int         OFFSET_BG_Y = 150,
   parameter int         BG_H        = 240,
   parameter int         ROAD_X_MIN  = 40,
   parameter int         SPEED       = 2,
   parameter int         MAX_SPEED   = 6,
   parameter int         GAP_FRAMES  = 4,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input logic               clk,
   input logic               reset_n,
   rival_spawn_ctrl_if.master bus
);

   localparam logic [9:0] X_BASE     = 10'(OFFSET_BG_X + ROAD_X_MIN);
   localparam logic [9:0] Y_TOP      = 10'(OFFSET_BG_Y);
   localparam logic [9:0] Y_EXIT     = 10'(OFFSET_BG_Y + BG_H);
   localparam logic [9:0] SPEED_INIT = 10'((SPEED > MAX_SPEED) ? MAX_SPEED : SPEED);
   localparam logic [7:0] GAP_LOAD   = 8'(GAP_FRAMES);

   typedef enum logic [1:0] {
      ST_SPAWN = 2'd0,
      ST_MOVE  = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] lfsr;
   logic       lfsr_fb;
   logic [7:0] gap_cnt;
   logic [9:0] rival_x;
   logic [9:0] rival_y;
   logic       rival_valid;
   logic [6:0] rival_random;
   logic       respawn;
   logic [7:0] score;
   logic [7:0] score_inc;
   logic [9:0] speed;
   logic [9:0] y_next;

   // Keeps running through stop so the player's timing perturbs the next spawn lane.
   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[6:0], lfsr_fb};
      end
   end

`ifdef RIVAL_SPEEDUP_EN
   localparam logic [9:0] SPEED_CAP = 10'(MAX_SPEED);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         speed <= SPEED_INIT;
      end else if (!bus.stop && state == ST_MOVE && bus.frame_tick && y_next >= Y_EXIT
                   && score != 8'hFF && score_inc[2:0] == 3'd0 && speed < SPEED_CAP) begin
         speed <= speed + 10'd1;
      end
   end
`else
   assign speed = SPEED_INIT;
`endif

   assign y_next    = rival_y + speed;
   assign score_inc = (score == 8'hFF) ? score : score + 8'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_SPAWN;
         gap_cnt      <= 8'd0;
         rival_x      <= X_BASE;
         rival_y      <= Y_TOP;
         rival_valid  <= 1'b0;
         rival_random <= 7'd0;
         respawn      <= 1'b0;
         score        <= 8'd0;
      end else begin
         respawn <= 1'b0;
         if (!bus.stop) begin
            case (state)
               ST_SPAWN: begin
                  rival_random <= lfsr[6:0];
                  rival_x      <= X_BASE + {3'b000, lfsr[6:0]};
                  rival_y      <= Y_TOP;
                  rival_valid  <= 1'b1;
                  respawn      <= 1'b1;
                  state        <= ST_MOVE;
               end
               ST_MOVE: begin
                  if (bus.frame_tick) begin
                     // On exit the rival stays at its last drawn row; only valid drops.
                     if (y_next >= Y_EXIT) begin
                        rival_valid <= 1'b0;
                        score       <= score_inc;
                        gap_cnt     <= GAP_LOAD;
                        state       <= ST_GAP;
                     end else begin
                        rival_y <= y_next;
                     end
                  end
               end
               ST_GAP: begin
                  if (bus.frame_tick) begin
                     if (gap_cnt <= 8'd1) begin
                        gap_cnt <= 8'd0;
                        state   <= ST_SPAWN;
                     end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                     end
                  end
               end
               default: state <= ST_SPAWN;
            endcase
         end
      end
   end

   assign bus.rival_x      = rival_x;
   assign bus.rival_y      = rival_y;
   assign bus.rival_valid  = rival_valid;
   assign bus.rival_random = rival_random;
   assign bus.respawn      = respawn;
   assign bus.score        = score;

endmodule

// File: doc/rival_spawn_ctrl.md
# rival_spawn_ctrl

Rival-car motion and respawn controller for the racing display. It owns the 8-bit LFSR, places each new rival at a random lane offset at the top of the road, and advances it down the background once per video frame. It counts rivals the player clears and freezes everything except the LFSR while the car FSM asserts `stop`. Its position outputs feed the sprite renderer and the collision comparator directly.

## Interface
Parameters:
- `OFFSET_BG_X`, 200: screen X of the background's left edge.
- `OFFSET_BG_Y`, 150: screen Y of the background's top edge; this is the rival spawn Y.
- `BG_H`, 240: background height in pixels.
- `ROAD_X_MIN`, 40: road left margin inside the background.
- `SPEED`, 2: rival pixels advanced per frame.
- `MAX_SPEED`, 6: speed cap; used only with `RIVAL_SPEEDUP_EN`.
- `GAP_FRAMES`, 4: number of frames with no rival between exit and respawn.
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  100 MHz system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per video frame, from the VGA timing block.
- `stop`  in  1  freeze request from the car FSM; level-sensitive.
- `rival_x`  out  10  rival screen X.
- `rival_y`  out  10  rival screen Y.
- `rival_valid`  out  1  rival is on the road and must be drawn and collision-checked.
- `rival_random`  out  7  LFSR value latched at the last spawn.
- `respawn`  out  1  one-cycle pulse in the cycle after a spawn load.
- `score`  out  8  number of rivals cleared; saturates at 255.

## Operation
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts left.
  - Shifts every clock, including while `stop` is high; this way the user's timing seeds the randomness.
  - Holds `LFSR_SEED` only while in reset.
- States:
  - SPAWN, single cycle:
    - Latch `rival_random` ← lfsr[6:0] (pre-shift register value).
    - Load `rival_x` ← `OFFSET_BG_X` + `ROAD_X_MIN` + lfsr[6:0], and `rival_y` ← `OFFSET_BG_Y`.
    - Set `rival_valid` = 1 and go to MOVE.
  - MOVE, on each `frame_tick`:
    - Compute y_next = `rival_y` + speed.
    - If y_next ≥ `OFFSET_BG_Y` + `BG_H`: clear `rival_valid`, increment `score` (saturating), load the gap counter with `GAP_FRAMES`, go to GAP. `rival_y` is left unchanged.
    - Otherwise `rival_y` ← y_next.
  - GAP: each `frame_tick` decrements the gap counter; on the tick that takes it to 0, go to SPAWN.
- Freeze: while `stop` is 1, state, positions, gap counter, speed and score all hold; `frame_tick` is ignored.
  - Deasserting `stop` resumes from the held state; no extra tick is needed.
- Simultaneous `stop` and `frame_tick`: the tick is discarded.
- SPAWN with `stop` high waits in SPAWN. It does not sample or pulse until `stop` falls, and then samples the current LFSR value.
- Arithmetic:
  - Sums are 10 bits, unsigned.
  - With the defaults, x stays within 240..367 and y stays ≤ 389; no overflow handling is required.

## Timing
- Reset values:
  - `rival_x` = `OFFSET_BG_X` + `ROAD_X_MIN` (240); `rival_y` = `OFFSET_BG_Y` (150).
  - `rival_valid` = 0, `rival_random` = 0, `respawn` = 0, `score` = 0.
  - State = SPAWN; LFSR = `LFSR_SEED`.
- The first clock edge after `reset_n` rises executes SPAWN (when `stop` = 0).
- Outputs are registered. The new position is visible 1 cycle after the SPAWN edge, in the same cycle that `respawn` is high.
- A `frame_tick` in MOVE updates `rival_y` 1 cycle later.
- Asserting `reset_n` low mid-operation forces the reset values immediately, without waiting for a clock edge.
- Full lap at defaults, from spawn to `rival_valid` falling: 119 moves (150 → 388) plus the exit tick, i.e. 120 frame ticks. Respawn follows `GAP_FRAMES` (4) ticks later.

## Configuration
- `RIVAL_SPEEDUP_EN` defined:
  - Speed starts at `SPEED` and increases by 1 each time `score` crosses a multiple of 8, capped at `MAX_SPEED`.
  - Speed resets to `SPEED` on reset.
- `RIVAL_SPEEDUP_EN` undefined: speed is the constant `SPEED`, and no speed register exists.

## Test plan
- Reset release with `stop` = 0 → one cycle later: `respawn` = 1, `rival_random` = 7'h25, `rival_x` = 277, `rival_y` = 150, `rival_valid` = 1.
- 120 `frame_tick`s with `stop` = 0 → `rival_y` steps 150, 152, … 388. On the 120th tick: `rival_valid` = 0 and `score` = 1. After 4 more ticks: `respawn` pulse, `rival_y` = 150, and the new `rival_x` equals 240 + `rival_random`.
- `stop` = 1 at `rival_y` = 300 while 50 ticks are applied → `rival_y`, `score` and state are unchanged. After `stop` falls, the next tick gives `rival_y` = 302.
- `stop` and `frame_tick` asserted in the same cycle, then `stop` dropped → no movement from that tick.
- `reset_n` pulsed low in GAP with `score` = 3 → outputs go to the reset values immediately; the post-release spawn yields `rival_random` = 7'h25 again.
- `RIVAL_SPEEDUP_EN`: after `score` reaches 8 → y increments become 3 per tick; after score 40 → increments are capped at 6.
